// File: rtl/fetch.sv
// Instruction-fetch stage: program counter, instruction register and a fixed
// instruction ROM, sequenced by the controller's T0 (fetch) and T1 (advance) phases.
module fetch #(
    parameter int          ADDR_BITS = 8,
    parameter logic [15:0] PC_RESET  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        T0,
    input  logic        T1,
    output logic [15:0] PC_out,
    output logic [15:0] IR
);

    logic [15:0]          pc_q;
    logic [15:0]          pc_d;
    logic [15:0]          ir_q;
    logic [15:0]          ir_d;
    logic [15:0]          rom_data;
    logic [ADDR_BITS-1:0] rom_addr;

    // Only the low PC bits index the ROM, so higher addresses alias onto it.
    assign rom_addr = pc_q[ADDR_BITS-1:0];

    always_comb begin
        rom_data = 16'h0000;
        case (rom_addr)
            ADDR_BITS'(0): rom_data = 16'h0020;
            ADDR_BITS'(1): rom_data = 16'h0841;
            ADDR_BITS'(2): rom_data = 16'h1062;
            ADDR_BITS'(3): rom_data = 16'h1883;
            ADDR_BITS'(4): rom_data = 16'h20A4;
            ADDR_BITS'(5): rom_data = 16'h28C5;
            ADDR_BITS'(6): rom_data = 16'h30E6;
            ADDR_BITS'(7): rom_data = 16'h3907;
            default:       rom_data = 16'h0000;
        endcase
    end

    // Both phases may be active together; IR always sees the pre-edge PC.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (T0) ir_d = rom_data;
        if (T1) pc_d = pc_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
            ir_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign PC_out = pc_q;
    assign IR     = ir_q;

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage: reset, fetch/advance,
// hold, PC wrap, ROM aliasing and asynchronous mid-run reset.
module tb_fetch;

    logic        clk;
    logic        rst_n;
    logic        T0;
    logic        T1;
    logic [15:0] PC_out;
    logic [15:0] IR;

    int n_tests;
    int n_fail;

    logic [15:0] exp_rom [0:7];

    fetch #(.ADDR_BITS(8), .PC_RESET(16'h0000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .T0     (T0),
        .T1     (T1),
        .PC_out (PC_out),
        .IR     (IR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_rom[0] = 16'h0020; exp_rom[1] = 16'h0841;
        exp_rom[2] = 16'h1062; exp_rom[3] = 16'h1883;
        exp_rom[4] = 16'h20A4; exp_rom[5] = 16'h28C5;
        exp_rom[6] = 16'h30E6; exp_rom[7] = 16'h3907;

        rst_n = 1'b0;
        T0    = 1'b0;
        T1    = 1'b0;
        #2;
        check("reset_pc_async", PC_out, 16'h0000);
        check("reset_ir_async", IR, 16'h0000);
        T0 = 1'b1;
        T1 = 1'b1;
        tick();
        tick();
        check("reset_pc_hold", PC_out, 16'h0000);
        check("reset_ir_hold", IR, 16'h0000);

        T0 = 1'b0;
        T1 = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check("idle_pc", PC_out, 16'h0000);
        check("idle_ir", IR, 16'h0000);

        T0 = 1'b1;
        tick();
        check("fetch0_ir", IR, 16'h0020);
        check("fetch0_pc", PC_out, 16'h0000);

        T1 = 1'b1;
        tick();
        check("adv0_ir", IR, 16'h0020);
        check("adv0_pc", PC_out, 16'h0001);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("run%0d_ir", i), IR, exp_rom[i]);
            check($sformatf("run%0d_pc", i), PC_out, 16'(i + 1));
        end

        T0 = 1'b0;
        T1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_pc", i), PC_out, 16'h0008);
            check($sformatf("hold%0d_ir", i), IR, 16'h3907);
        end

        T1 = 1'b1;
        repeat (65527) tick();
        check("pc_max", PC_out, 16'hFFFF);
        check("pc_max_ir", IR, 16'h3907);
        tick();
        check("pc_wrap", PC_out, 16'h0000);
        repeat (256) tick();
        check("pc_0100", PC_out, 16'h0100);

        T1 = 1'b0;
        T0 = 1'b1;
        tick();
        check("alias0_ir", IR, 16'h0020);
        check("alias0_pc", PC_out, 16'h0100);
        T0 = 1'b0;
        T1 = 1'b1;
        repeat (3) tick();
        T1 = 1'b0;
        T0 = 1'b1;
        tick();
        check("alias3_ir", IR, 16'h1883);
        check("alias3_pc", PC_out, 16'h0103);

        T1 = 1'b1;
        tick();
        check("pre_rst_pc", PC_out, 16'h0104);
        check("pre_rst_ir", IR, 16'h1883);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_pc", PC_out, 16'h0000);
        check("midrst_ir", IR, 16'h0000);
        tick();
        check("midrst_hold_pc", PC_out, 16'h0000);
        check("midrst_hold_ir", IR, 16'h0000);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_ir", IR, 16'h0020);
        check("post_rst_pc", PC_out, 16'h0001);
        tick();
        check("post_rst2_ir", IR, 16'h0841);
        check("post_rst2_pc", PC_out, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the 16-bit RISC processor.
- Holds the program counter (PC) and the instruction register (IR), and contains an internal read-only instruction memory.
- Under control of the two timing phases T0 and T1 from the controller's beat generator, it latches the instruction at the current PC into IR and advances the PC.
- PC and IR are exported to the decode/execute stages.

Parameters:
- ADDR_BITS, 8: number of low PC bits used to index the instruction ROM. ROM depth is 2^ADDR_BITS words.
- PC_RESET, 16'h0000: value loaded into PC on reset.

Ports:
- clk, input, 1: system clock. All state updates occur on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- T0, input, 1: fetch phase enable. While high, IR loads ROM[PC] on each rising clk edge.
- T1, input, 1: PC-advance phase enable. While high, PC increments by 1 on each rising clk edge.
- PC_out, output, 16: current PC register value (registered, not combinational with the increment).
- IR, output, 16: instruction register. Format is opcode[15:11], rd[10:8], rs[7:5], imm/func[4:0].

Behaviour:
- Reset (rst_n = 0, asynchronous): PC <= PC_RESET and IR <= 16'h0000 immediately, independent of clk. Both hold while rst_n is low; T0 and T1 are ignored.
- ROM:
  - Combinational read, ROM[PC[ADDR_BITS-1:0]]. Upper PC bits are ignored, so addresses alias.
  - Fixed contents:
    - word0 = 16'h0020 (00000_000_001_00000)
    - word1 = 16'h0841
    - word2 = 16'h1062
    - word3 = 16'h1883
    - word4 = 16'h20A4
    - word5 = 16'h28C5
    - word6 = 16'h30E6
    - word7 = 16'h3907
    - all other words = 16'h0000
- Rising clk edge, rst_n = 1:
  - T0 = 1: IR <= ROM[PC], using the PC value before this edge.
  - T1 = 1: PC <= PC + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - T0 = 1 and T1 = 1 on the same edge: both updates happen. IR gets ROM[old PC] and PC becomes old PC + 1.
  - T0 = 0 and T1 = 0: PC and IR hold.
- Latency: one clock edge from the T0 sample to the IR update, and one edge from the T1 sample to the PC update. No other pipeline delay.
- PC_out is driven directly from the PC register. IR is driven directly from the IR register.
- Reset asserted mid-operation overrides any in-progress phase. After release, the first active edge uses PC = PC_RESET.
- No handshake. Phases are level-sensitive enables sampled at clock edges. The controller guarantees the phase sequencing.

Test Plan:
1. Reset: rst_n = 0 with T0 = T1 = 0 -> PC_out = 16'h0000 and IR = 16'h0000 immediately (asynchronous). Both hold across clock edges.
2. Fetch at the default PC: release reset, clk period 10 ns, T0 rises at 20 ns -> at the next rising edge IR = 16'h0020 and PC_out = 16'h0000.
3. Advance: T0 stays high, T1 rises at 40 ns -> after the first edge with T1 high, PC_out = 16'h0001. With both held high, each subsequent edge gives IR = ROM[previous PC] (16'h0841, 16'h1062, ...) and the PC increments.
4. Hold: T0 = T1 = 0 for 5 edges -> PC_out and IR unchanged.
5. Wrap and aliasing:
   - Drive T1 only until PC = 16'hFFFF; the next T1 edge -> PC_out = 16'h0000.
   - At PC = 16'h0100, pulse T0 -> IR = 16'h0020 (ROM aliases to word 0).
6. Mid-run reset: assert rst_n = 0 asynchronously between edges while T0 = T1 = 1 -> PC_out and IR go to 0 at once. After release, the first edge -> IR = 16'h0020 and PC_out = 16'h0001.
